// File: rtl/ltm_pkg.sv
// ltm_pkg: shared widths and refill FSM encoding for the LTM pixel path
package ltm_pkg;
  localparam int LTM_PIX_W = 32;
  localparam int LTM_HALF_W = 16;
  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} fillState_t;
endpackage

// File: rtl/ltm_pixel_fifo_if.sv
// ltm_pixel_fifo_if: write handshake, pop and status bundle of the pixel FIFO
//   wrData/wrValid/wrReady  packed pixel word handshake from SDRAM
//   rdEn                    pop request from the timing controller
//   readData1/readData2     popped word halves [31:16] / [15:0]
//   level/refillReq/underflow  occupancy, burst request, sticky empty-pop flag
interface ltm_pixel_fifo_if import ltm_pkg::*; #(parameter int DEPTH_LOG2 = 9);
  logic [LTM_PIX_W-1:0] wrData;
  logic wrValid;
  logic wrReady;
  logic rdEn;
  logic [LTM_HALF_W-1:0] readData1;
  logic [LTM_HALF_W-1:0] readData2;
  logic [DEPTH_LOG2:0] level;
  logic refillReq;
  logic underflow;
  modport master(output wrData, wrValid, rdEn, input wrReady, readData1, readData2, level, refillReq, underflow);
  modport slave(input wrData, wrValid, rdEn, output wrReady, readData1, readData2, level, refillReq, underflow);
endinterface

// File: rtl/ltm_fifo_ram.sv
// ltm_fifo_ram: simple dual-port block RAM with registered read
//   iCLK            clock
//   wrEn/wrAddr/wrData  write port
//   rdEn/rdAddr     read port; rdData updates only when rdEn is high
//   rdData          registered read word
module ltm_fifo_ram import ltm_pkg::*; #(parameter int DEPTH_LOG2 = 9) (
  input  logic iCLK,
  input  logic wrEn,
  input  logic [DEPTH_LOG2-1:0] wrAddr,
  input  logic [LTM_PIX_W-1:0] wrData,
  input  logic rdEn,
  input  logic [DEPTH_LOG2-1:0] rdAddr,
  output logic [LTM_PIX_W-1:0] rdData
);
  logic [LTM_PIX_W-1:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge iCLK) begin
    if (wrEn) mem[wrAddr] <= wrData;
    if (rdEn) rdData <= mem[rdAddr];
  end
endmodule

// File: rtl/ltm_pixel_fifo.sv
// ltm_pixel_fifo: pixel prefetch FIFO with watermark refill requests and frame-start flush
//   iCLK          pixel clock
//   iRST_n        asynchronous active-low reset
//   iFRAME_START  one-cycle flush pulse, overrides every other event
//   bus           slave side of ltm_pixel_fifo_if (write handshake, pop, status)
module ltm_pixel_fifo import ltm_pkg::*; #(
  parameter int DEPTH_LOG2 = 9,
  parameter int LOW_WM = 128,
  parameter int HIGH_WM = 448
) (
  input  logic iCLK,
  input  logic iRST_n,
  input  logic iFRAME_START,
  ltm_pixel_fifo_if.slave bus
);
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] LOW = (DEPTH_LOG2+1)'(LOW_WM);
  localparam logic [DEPTH_LOG2:0] HIGH = (DEPTH_LOG2+1)'(HIGH_WM);
  logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
  logic [DEPTH_LOG2:0] level;
  logic [LTM_PIX_W-1:0] ramQ;
  logic zeroSel, underflow, empty, wrAcc, rdAcc;
  fillState_t state, nextState;
  assign empty = level == '0;
  assign bus.wrReady = iRST_n && level != FULL && !iFRAME_START;
  assign wrAcc = bus.wrValid && bus.wrReady;
  assign rdAcc = bus.rdEn && !empty && !iFRAME_START;
  ltm_fifo_ram #(.DEPTH_LOG2(DEPTH_LOG2)) ram (
    .iCLK(iCLK),
    .wrEn(wrAcc),
    .wrAddr(wrPtr),
    .wrData(bus.wrData),
    .rdEn(rdAcc),
    .rdAddr(rdPtr),
    .rdData(ramQ)
  );
  // zeroSel masks the RAM output after reset, flush or an empty pop; it only
  // changes on a pop or flush so the presented word holds while rdEn is low
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
      zeroSel <= 1'b1;
      underflow <= 1'b0;
    end else if (iFRAME_START) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
      zeroSel <= 1'b1;
      underflow <= 1'b0;
    end else begin
      if (wrAcc) wrPtr <= wrPtr + 1'b1;
      if (rdAcc) rdPtr <= rdPtr + 1'b1;
      level <= level + (DEPTH_LOG2+1)'(wrAcc) - (DEPTH_LOG2+1)'(rdAcc);
      if (bus.rdEn) zeroSel <= empty;
      underflow <= underflow | (bus.rdEn & empty);
    end
  end
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= IDLE;
    else state <= nextState;
  end
  always_comb begin
    nextState = iFRAME_START ? IDLE :
                state == IDLE ? (level < LOW ? FILL : IDLE) :
                (level >= HIGH ? IDLE : FILL);
  end
  assign bus.readData1 = zeroSel ? '0 : ramQ[LTM_PIX_W-1:LTM_HALF_W];
  assign bus.readData2 = zeroSel ? '0 : ramQ[LTM_HALF_W-1:0];
  assign bus.level = level;
  assign bus.refillReq = state == FILL;
  assign bus.underflow = underflow;
endmodule
